// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshake and a held result register.
// Define ALU_MC_DIV_EN to build the iterative divider for ops 16-19.
module alu_mc #(
   parameter int WIDTH      = 32,
   parameter int MUL_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] R,
   output logic             zero
);
   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = $clog2(WIDTH + MUL_STAGES + 2);
   localparam logic [CW-1:0] MUL_LAST = CW'(MUL_STAGES - 1);

   typedef enum logic [4:0] {
      OP_AND    = 5'd0,  OP_OR   = 5'd1,  OP_XOR    = 5'd2,  OP_ADD   = 5'd3,
      OP_SUB    = 5'd4,  OP_MUL  = 5'd5,  OP_MULH   = 5'd6,  OP_MULHU = 5'd7,
      OP_MULHSU = 5'd8,  OP_SLL  = 5'd9,  OP_SRL    = 5'd10, OP_SRA   = 5'd11,
      OP_SLT    = 5'd12, OP_SLTU = 5'd13, OP_DIV    = 5'd16, OP_DIVU  = 5'd17,
      OP_REM    = 5'd18, OP_REMU = 5'd19
   } op_e;

   typedef enum logic [2:0] {IDLE, EXEC, MUL, DIV, DONE} state_e;

   state_e             state;
   logic [4:0]         op_r;
   logic [WIDTH-1:0]   a_r, b_r;
   logic [CW-1:0]      cnt;
   logic [SHW-1:0]     shamt;
   logic [WIDTH-1:0]   alu_res, mul_res;
   logic [2*WIDTH-1:0] mul_a, mul_b, prod;
   logic               is_mul;

   assign is_mul = (op >= OP_MUL) && (op <= OP_MULHSU);

   always_comb begin
      shamt   = b_r[SHW-1:0];
      alu_res = '0;
      case (op_r)
         OP_AND:  alu_res = a_r & b_r;
         OP_OR:   alu_res = a_r | b_r;
         OP_XOR:  alu_res = a_r ^ b_r;
         OP_ADD:  alu_res = a_r + b_r;
         OP_SUB:  alu_res = a_r - b_r;
         OP_SLL:  alu_res = a_r << shamt;
         OP_SRL:  alu_res = a_r >> shamt;
         OP_SRA:  alu_res = $signed(a_r) >>> shamt;
         OP_SLT:  alu_res[0] = $signed(a_r) < $signed(b_r);
         OP_SLTU: alu_res[0] = a_r < b_r;
         default: alu_res = '0;
      endcase
   end

   // One 2W x 2W multiplier; operand extension selects the signedness of each side.
   always_comb begin
      mul_a   = {{WIDTH{((op_r == OP_MULH) || (op_r == OP_MULHSU)) & a_r[WIDTH-1]}}, a_r};
      mul_b   = {{WIDTH{(op_r == OP_MULH) & b_r[WIDTH-1]}}, b_r};
      prod    = mul_a * mul_b;
      mul_res = (op_r == OP_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
   end

`ifdef ALU_MC_DIV_EN
   localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH + 1);

   logic             is_div;
   logic [WIDTH-1:0] quo_r, rem_r, dvs_r, quo_fix, rem_fix, div_res;
   logic [WIDTH:0]   shifted, trial;
   logic             div_signed, a_neg, b_neg;

   assign is_div = (op >= OP_DIV) && (op <= OP_REMU);

   always_comb begin
      div_signed = (op_r == OP_DIV) || (op_r == OP_REM);
      a_neg      = div_signed & a_r[WIDTH-1];
      b_neg      = div_signed & b_r[WIDTH-1];
      shifted    = {rem_r, quo_r[WIDTH-1]};
      trial      = shifted - {1'b0, dvs_r};
      quo_fix    = (a_neg ^ b_neg) ? -quo_r : quo_r;
      rem_fix    = a_neg ? -rem_r : rem_r;
      // Divide by zero leaves quotient magnitude all-ones and remainder = |A|;
      // only the signed quotient needs overriding.
      if ((op_r == OP_DIV) || (op_r == OP_DIVU))
         div_res = (b_r == '0) ? '1 : quo_fix;
      else
         div_res = rem_fix;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         R         <= '0;
         zero      <= 1'b1;
         op_r      <= '0;
         a_r       <= '0;
         b_r       <= '0;
         cnt       <= '0;
`ifdef ALU_MC_DIV_EN
         quo_r     <= '0;
         rem_r     <= '0;
         dvs_r     <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_r     <= op;
                  a_r      <= A;
                  b_r      <= B;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  if (is_mul)
                     state <= MUL;
`ifdef ALU_MC_DIV_EN
                  else if (is_div)
                     state <= DIV;
`endif
                  else
                     state <= EXEC;
               end
            end
            EXEC: begin
               R         <= alu_res;
               zero      <= (alu_res == '0);
               out_valid <= 1'b1;
               state     <= DONE;
            end
            MUL: begin
               if (cnt == MUL_LAST) begin
                  R         <= mul_res;
                  zero      <= (mul_res == '0);
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
`ifdef ALU_MC_DIV_EN
            // cnt 0: load magnitudes; 1..WIDTH: restoring steps; WIDTH+1: sign fixup.
            DIV: begin
               cnt <= cnt + CW'(1);
               if (cnt == '0) begin
                  quo_r <= a_neg ? -a_r : a_r;
                  dvs_r <= b_neg ? -b_r : b_r;
                  rem_r <= '0;
               end else if (cnt == DIV_LAST) begin
                  R         <= div_res;
                  zero      <= (div_res == '0);
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  rem_r <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                  quo_r <= {quo_r[WIDTH-2:0], ~trial[WIDTH]};
               end
            end
`endif
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: 32-bit/3-stage-multiply instance plus an 8-bit instance.
// Divider expectations follow ALU_MC_DIV_EN.
module tb_alu_mc;

`ifdef ALU_MC_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   typedef enum logic [4:0] {
      OP_AND    = 5'd0,  OP_OR   = 5'd1,  OP_XOR    = 5'd2,  OP_ADD   = 5'd3,
      OP_SUB    = 5'd4,  OP_MUL  = 5'd5,  OP_MULH   = 5'd6,  OP_MULHU = 5'd7,
      OP_MULHSU = 5'd8,  OP_SLL  = 5'd9,  OP_SRL    = 5'd10, OP_SRA   = 5'd11,
      OP_SLT    = 5'd12, OP_SLTU = 5'd13, OP_DIV    = 5'd16, OP_DIVU  = 5'd17,
      OP_REM    = 5'd18, OP_REMU = 5'd19
   } op_e;

   typedef struct {
      logic [31:0] r;
      logic        z;
      int          lat;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready, zero;
   logic [4:0]  op_i;
   logic [31:0] a_i, b_i, r_o;

   logic        in_valid8, in_ready8, out_valid8, out_ready8, zero8;
   logic [4:0]  op8;
   logic [7:0]  a8, b8, r8;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   logic ov_prev = 1'b0;
   exp_t exp_q[$];
   exp_t q8[$];

   alu_mc #(.WIDTH(32), .MUL_STAGES(3)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op_i),
      .A(a_i), .B(b_i), .out_valid(out_valid), .out_ready(out_ready), .R(r_o), .zero(zero)
   );

   alu_mc #(.WIDTH(8), .MUL_STAGES(1)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
      .A(a8), .B(b8), .out_valid(out_valid8), .out_ready(out_ready8), .R(r8), .zero(zero8)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Offer one op to the 32-bit instance, record the expectation after the accept edge.
   task automatic send(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] e, input int lat);
      int n;
      n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) check("send_ready_timeout", 64'(in_ready), 64'(1));
      op_i = o; a_i = x; b_i = y; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      exp_q.push_back('{r: e, z: (e == '0), lat: lat, acc: cyc});
      op_i = 5'($urandom); a_i = $urandom; b_i = $urandom;
   endtask

   task automatic sendd(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] e);
      send(o, x, y, DIV_EN ? e : 32'd0, DIV_EN ? 34 : 1);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
   endtask

   task automatic send8(input logic [4:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] e, input int lat);
      int n;
      check("in_ready8", 64'(in_ready8), 64'(1));
      op8 = o; a8 = x; b8 = y; in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom);
      q8.push_back('{r: 32'(e), z: (e == 8'd0), lat: lat, acc: cyc});
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!out_valid8 && n < 100);
      check("lat8", 64'(n), 64'(q8[0].lat));
      check("R8", 64'(r8), 64'(q8[0].r));
      check("zero8", 64'(zero8), 64'(q8[0].z));
      void'(q8.pop_front());
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && !ov_prev) begin
         if (exp_q.size() == 0)
            check("spurious_out_valid", 64'(out_valid), 64'(0));
         else
            check("latency", 64'(cyc - exp_q[0].acc), 64'(exp_q[0].lat));
      end
      if (!rst && out_valid && out_ready && exp_q.size() != 0) begin
         check("R", 64'(r_o), 64'(exp_q[0].r));
         check("zero", 64'(zero), 64'(exp_q[0].z));
         void'(exp_q.pop_front());
      end
      ov_prev <= out_valid;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op_i = '0; a_i = '0; b_i = '0;
      in_valid8 = 1'b0; out_ready8 = 1'b1; op8 = '0; a8 = '0; b8 = '0;
      #2 rst = 1'b1;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'(1));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_R", 64'(r_o), 64'(0));
      check("rst_zero", 64'(zero), 64'(1));
      check("rst_R8", 64'(r8), 64'(0));
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // single-cycle ops
      send(OP_SUB,  32'd5,        32'd7,        32'hFFFFFFFE, 1);
      send(OP_SRA,  32'h80000000, 32'h00000024, 32'hF8000000, 1);
      send(OP_SRA,  32'h80000001, 32'h00000020, 32'h80000001, 1);
      send(OP_SLT,  32'hFFFFFFFF, 32'd1,        32'd1,        1);
      send(OP_SLTU, 32'hFFFFFFFF, 32'd1,        32'd0,        1);
      send(OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1);
      send(OP_OR,   32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1);
      send(OP_XOR,  32'h12345678, 32'h12345678, 32'h00000000, 1);
      send(OP_ADD,  32'hFFFFFFFF, 32'd1,        32'h00000000, 1);
      send(OP_SLL,  32'd1,        32'h0000003F, 32'h80000000, 1);
      send(OP_SRL,  32'h80000000, 32'h0000001F, 32'h00000001, 1);
      send(5'd14,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1);
      send(5'd31,   32'h00000005, 32'h00000003, 32'h00000000, 1);

      // multiply, 3-cycle latency
      send(OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 3);
      send(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 3);
      send(OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 3);
      send(OP_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 3);
      send(OP_MUL,    32'd12345,    32'd678,      32'd8369910,  3);
      send(OP_MUL,    32'h00010000, 32'h00010000, 32'h00000000, 3);

      // divide (single-cycle zero when the divider is not built)
      sendd(OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
      sendd(OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
      sendd(OP_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD);
      sendd(OP_REM,  32'd7,        32'hFFFFFFFE, 32'd1);
      sendd(OP_DIVU, 32'd7,        32'd0,        32'hFFFFFFFF);
      sendd(OP_REM,  32'd7,        32'd0,        32'd7);
      sendd(OP_DIV,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF);
      sendd(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000);
      sendd(OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0);
      sendd(OP_DIVU, 32'd100,      32'd7,        32'd14);
      sendd(OP_REMU, 32'd100,      32'd7,        32'd2);
      wait_done();

      // backpressure: result held, further offers ignored
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(OP_ADD, 32'd1, 32'd1, 32'd2, 1);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            in_valid = 1'b1; op_i = OP_XOR; a_i = 32'h0000FFFF; b_i = 32'h00FF00FF;
         end
         @(negedge clk);
         check("bp_out_valid", 64'(out_valid), 64'(1));
         check("bp_in_ready", 64'(in_ready), 64'(0));
         check("bp_R", 64'(r_o), 64'(2));
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_done();
      @(posedge clk); #1;
      check("bp_no_extra_op", 64'(out_valid), 64'(0));

      // reset while an operation is in flight
      if (DIV_EN) begin
         send(OP_DIV, 32'd100, 32'd7, 32'd14, 34);
         repeat (4) @(posedge clk);
      end else begin
         send(OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 3);
         repeat (1) @(posedge clk);
      end
      #2 rst = 1'b1;
      exp_q.delete();
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'(0));
      check("midrst_in_ready", 64'(in_ready), 64'(1));
      check("midrst_R", 64'(r_o), 64'(0));
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("postrst_out_valid", 64'(out_valid), 64'(0));
      end
      send(OP_ADD, 32'd3, 32'd4, 32'd7, 1);
      wait_done();

      // 8-bit instance, single-cycle multiply
      send8(OP_SLL,   8'h81, 8'h09, 8'h02, 1);
      send8(OP_MUL,   8'd16, 8'd16, 8'h00, 1);
      send8(OP_MULH,  8'h80, 8'h80, 8'h40, 1);
      send8(OP_MULHU, 8'hFF, 8'hFF, 8'hFE, 1);
      send8(OP_ADD,   8'hFF, 8'h02, 8'h01, 1);
      send8(OP_SRA,   8'h80, 8'h0F, 8'hFF, 1);
      send8(5'd16,    8'd100, 8'd7, DIV_EN ? 8'd14 : 8'd0, DIV_EN ? 10 : 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
